// File: rtl/mac_multiplex_sequencer.sv
// Job sequencer for one precision-scalable multiplex MAC: clear, stream, drain, return result.
// Optional MAC_SEQ_OVF_CHECK_EN adds res_ovf (job length exceeds the lane guard-bit headroom).
module mac_multiplex_sequencer #(
  parameter int W_WIDTH         = 8,
  parameter int A_WIDTH         = 8,
  parameter int PLUS_WIDTH      = 4,
  parameter int CONFIG_AW_WIDTH = 2,
  parameter int LEN_WIDTH       = 8,
  parameter int MAC_LATENCY     = 2,
  localparam int Z_WIDTH = W_WIDTH + A_WIDTH + (2**CONFIG_AW_WIDTH) * PLUS_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  input  logic [CONFIG_AW_WIDTH-1:0] cmd_config_aw,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W_WIDTH-1:0]         in_w,
  input  logic [A_WIDTH-1:0]         in_a,
  output logic                       mac_accu_rst,
  output logic [CONFIG_AW_WIDTH-1:0] mac_config_aw,
  output logic [W_WIDTH-1:0]         mac_w,
  output logic [A_WIDTH-1:0]         mac_a,
  input  logic [Z_WIDTH-1:0]         mac_z,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [Z_WIDTH-1:0]         res_z,
`ifdef MAC_SEQ_OVF_CHECK_EN
  output logic                       res_ovf,
`endif
  output logic                       busy
);

  // Drain covers the operand output register plus the MAC's own latency.
  localparam int DRAIN_CW = $clog2(MAC_LATENCY + 2);
  localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(MAC_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state, state_next;
  logic [LEN_WIDTH-1:0] remaining;
  logic [DRAIN_CW-1:0]  drain_cnt;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    in_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = S_CLEAR;
      end
      S_CLEAR: state_next = (remaining != '0) ? S_RUN : S_DRAIN;
      S_RUN: begin
        in_ready = 1'b1;
        if (in_valid && remaining == LEN_WIDTH'(1)) state_next = S_DRAIN;
      end
      S_DRAIN: if (drain_cnt == DRAIN_LAST) state_next = S_DONE;
      S_DONE:  if (res_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      remaining     <= '0;
      drain_cnt     <= '0;
      mac_accu_rst  <= 1'b0;
      mac_config_aw <= '0;
      mac_w         <= '0;
      mac_a         <= '0;
      res_valid     <= 1'b0;
      res_z         <= '0;
    end else begin
      state        <= state_next;
      // Operands fall back to zero: the MAC has no enable, so idle cycles must add nothing.
      mac_accu_rst <= 1'b0;
      mac_w        <= '0;
      mac_a        <= '0;
      drain_cnt    <= '0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            remaining     <= cmd_len;
            mac_config_aw <= cmd_config_aw;
            mac_accu_rst  <= 1'b1;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            mac_w     <= in_w;
            mac_a     <= in_a;
            remaining <= remaining - 1'b1;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            res_z     <= mac_z;
            res_valid <= 1'b1;
          end
        end
        S_DONE: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef MAC_SEQ_OVF_CHECK_EN
  localparam int OVF_LIMIT = 2**PLUS_WIDTH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_ovf <= 1'b0;
    end else if (state == S_IDLE && cmd_valid) begin
      res_ovf <= (int'(cmd_len) > OVF_LIMIT);
    end
  end
`endif

endmodule

// File: tb/tb_mac_multiplex_sequencer.sv
// Self-checking bench for mac_multiplex_sequencer with a behavioural lane-split MAC attached.
// Expected results come from job-level lane sums over the operand lists.
module tb_mac_multiplex_sequencer;

  localparam int W_WIDTH = 8, A_WIDTH = 8, PLUS_WIDTH = 4, CONFIG_AW_WIDTH = 2;
  localparam int LEN_WIDTH = 8, MAC_LATENCY = 2;
  localparam int Z_WIDTH = W_WIDTH + A_WIDTH + (2**CONFIG_AW_WIDTH) * PLUS_WIDTH;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [LEN_WIDTH-1:0] cmd_len = '0;
  logic [CONFIG_AW_WIDTH-1:0] cmd_config_aw = '0;
  logic in_valid = 1'b0, in_ready;
  logic [W_WIDTH-1:0] in_w = '0;
  logic [A_WIDTH-1:0] in_a = '0;
  logic mac_accu_rst;
  logic [CONFIG_AW_WIDTH-1:0] mac_config_aw;
  logic [W_WIDTH-1:0] mac_w;
  logic [A_WIDTH-1:0] mac_a;
  logic [Z_WIDTH-1:0] mac_z;
  logic res_valid, res_ready = 1'b0;
  logic [Z_WIDTH-1:0] res_z;
  logic busy;
`ifdef MAC_SEQ_OVF_CHECK_EN
  logic res_ovf;
`endif

  always #5 clk = ~clk;

  mac_multiplex_sequencer #(
    .W_WIDTH(W_WIDTH), .A_WIDTH(A_WIDTH), .PLUS_WIDTH(PLUS_WIDTH),
    .CONFIG_AW_WIDTH(CONFIG_AW_WIDTH), .LEN_WIDTH(LEN_WIDTH), .MAC_LATENCY(MAC_LATENCY)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_config_aw(cmd_config_aw),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_a(in_a),
    .mac_accu_rst(mac_accu_rst), .mac_config_aw(mac_config_aw), .mac_w(mac_w), .mac_a(mac_a),
    .mac_z(mac_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z),
`ifdef MAC_SEQ_OVF_CHECK_EN
    .res_ovf(res_ovf),
`endif
    .busy(busy)
  );

  // Lane split: 2**cfg lanes, each w/a lane 8>>cfg bits, each z lane 32>>cfg bits, lane 0 at the LSBs.
  function automatic longint lane_val(logic [7:0] v, int lw, int i, bit sgn);
    longint u;
    u = longint'(v >> (i * lw)) & ((longint'(1) << lw) - 1);
    if (sgn && u >= (longint'(1) << (lw - 1))) u -= (longint'(1) << lw);
    return u;
  endfunction

  function automatic logic [31:0] mac_step(logic [31:0] acc, logic [7:0] w, logic [7:0] a, logic [1:0] cfg);
    int n, lw, zw;
    longint mask, cur;
    logic [31:0] r;
    n = 1 << cfg; lw = 8 >> cfg; zw = 32 >> cfg;
    mask = (longint'(1) << zw) - 1;
    r = '0;
    for (int i = 0; i < n; i++) begin
      cur = (longint'(acc) >> (i * zw)) & mask;
      cur = (cur + lane_val(w, lw, i, 1'b1) * lane_val(a, lw, i, 1'b0)) & mask;
      r |= 32'(cur << (i * zw));
    end
    return r;
  endfunction

  // Behavioural MAC: accumulator updates on the sample edge, one output stage makes MAC_LATENCY=2.
  logic [31:0] mac_acc, mac_zq;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_acc <= '0;
      mac_zq  <= '0;
    end else begin
      mac_acc <= mac_accu_rst ? 32'd0 : mac_step(mac_acc, mac_w, mac_a, mac_config_aw);
      mac_zq  <= mac_acc;
    end
  end
  assign mac_z = mac_zq;

  int accu_pulses = 0;
  always @(posedge clk) if (mac_accu_rst) accu_pulses++;

  int n_vec = 0, n_fail = 0;
  logic [7:0] job_w[$], job_a[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-job lane sums from the operand lists, wrapped to the lane width.
  function automatic logic [31:0] ref_job(logic [1:0] cfg, int len);
    int n, lw, zw;
    longint sum, mask;
    logic [31:0] z;
    n = 1 << cfg; lw = 8 >> cfg; zw = 32 >> cfg;
    mask = (longint'(1) << zw) - 1;
    z = '0;
    for (int i = 0; i < n; i++) begin
      sum = 0;
      for (int k = 0; k < len; k++)
        sum += lane_val(job_w[k], lw, i, 1'b1) * lane_val(job_a[k], lw, i, 1'b0);
      z |= 32'((sum & mask) << (i * zw));
    end
    return z;
  endfunction

  // gaps: 0 = in_valid always high, 1 = pattern 1,0,0,1,1 then high, 2 = random.
  task automatic do_job(input logic [1:0] cfg, input int len, input int gaps, input int rdelay,
                        input logic [31:0] exp);
    int idx, cyc, guard, edges, p0;
    bit hs;
    logic [4:0] pat;
    logic [31:0] held;
    pat = 5'b11001;
    p0 = accu_pulses;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_len = LEN_WIDTH'(len); cmd_config_aw = cfg;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("config_aw_loaded", mac_config_aw, cfg);
    idx = 0; cyc = 0; guard = 0;
    while (idx < len && guard < 200) begin
      if (in_ready) begin
        if (gaps == 1) in_valid = (cyc < 5) ? pat[cyc] : 1'b1;
        else if (gaps == 2) in_valid = 1'($urandom_range(0, 1));
        else in_valid = 1'b1;
        in_w = job_w[idx]; in_a = job_a[idx];
        cyc++;
      end else begin
        in_valid = 1'b0;
      end
      hs = in_valid && in_ready;
      @(posedge clk);
      if (hs) idx++;
      guard++;
      @(negedge clk);
      if (!hs && in_ready) check("idle_operands_zero", {mac_w, mac_a}, 0);
    end
    in_valid = 1'b0;
    check("pairs_consumed", idx, len);
    edges = 0;
    while (!res_valid && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("res_valid_seen", res_valid, 1);
    // Edges after the last handshake edge; including that edge gives MAC_LATENCY+2.
    if (len != 0) check("result_latency", edges, MAC_LATENCY + 1);
    check("res_z", res_z, exp);
    check("accu_rst_once", accu_pulses - p0, 1);
    check("config_aw_held", mac_config_aw, cfg);
`ifdef MAC_SEQ_OVF_CHECK_EN
    check("res_ovf", res_ovf, (len > 2**PLUS_WIDTH));
`endif
    held = res_z;
    for (int d = 0; d < rdelay; d++) begin
      @(negedge clk);
      check("hold_stable", {res_valid, res_z, cmd_ready, busy}, {1'b1, held, 1'b0, 1'b1});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_handshake_idle", {res_valid, busy, cmd_ready}, 3'b001);
  endtask

  typedef struct {
    logic [1:0]      cfg;
    int              len;
    logic [3:0][7:0] w;
    logic [3:0][7:0] a;
    logic [31:0]     exp;
    int              gaps;
    int              rdelay;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{2'd0, 3, {8'h00, 8'h04, 8'hFF, 8'h02}, {8'h00, 8'd10, 8'd5, 8'd3}, 32'd41, 0, 0};
    vecs[1] = '{2'd1, 2, {8'h00, 8'h00, 8'hE1, 8'hE1}, {8'h00, 8'h00, 8'h35, 8'h35}, 32'hFFF4000A, 0, 0};
    vecs[2] = '{2'd0, 3, {8'h00, 8'h04, 8'hFF, 8'h02}, {8'h00, 8'd10, 8'd5, 8'd3}, 32'd41, 1, 0};
    vecs[3] = '{2'd0, 3, {8'h00, 8'h04, 8'hFF, 8'h02}, {8'h00, 8'd10, 8'd5, 8'd3}, 32'd41, 0, 5};
    vecs[4] = '{2'd0, 0, '0, '0, 32'd0, 0, 0};
    vecs[5] = '{2'd2, 2, {8'h00, 8'h00, 8'hC0, 8'h01}, {8'h00, 8'h00, 8'hC0, 8'h03}, 32'hFD000003, 0, 0};
    vecs[6] = '{2'd3, 1, {8'h00, 8'h00, 8'h00, 8'hFF}, {8'h00, 8'h00, 8'h00, 8'hFF}, 32'hFFFFFFFF, 0, 0};

    #2;
    check("reset_outputs", {mac_accu_rst, mac_config_aw, mac_w, mac_a, res_valid, res_z, busy, cmd_ready, in_ready},
          {1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      job_w.delete(); job_a.delete();
      for (int k = 0; k < vecs[v].len; k++) begin
        job_w.push_back(vecs[v].w[k]);
        job_a.push_back(vecs[v].a[k]);
      end
      do_job(vecs[v].cfg, vecs[v].len, vecs[v].gaps, vecs[v].rdelay, vecs[v].exp);
    end

    // Reset in the middle of RUN after two of four pairs.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = 8'd4; cmd_config_aw = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    begin
      int got, guard;
      got = 0; guard = 0;
      while (got < 2 && guard < 20) begin
        in_valid = 1'b1; in_w = 8'h37; in_a = 8'h59;
        if (in_ready) got++;
        guard++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      check("pairs_before_rst", got, 2);
    end
    rst = 1'b1;
    #1;
    check("midrun_reset", {mac_accu_rst, mac_config_aw, mac_w, mac_a, res_valid, res_z, busy, cmd_ready, in_ready},
          {1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    job_w = '{8'd3}; job_a = '{8'd3};
    do_job(2'd0, 1, 0, 0, 32'd9);

    // Random jobs against the job-level reference.
    for (int j = 0; j < 25; j++) begin
      logic [1:0] cfg;
      int len;
      cfg = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 7);
      job_w.delete(); job_a.delete();
      for (int k = 0; k < len; k++) begin
        job_w.push_back(8'($urandom));
        job_a.push_back(8'($urandom));
      end
      do_job(cfg, len, 2, $urandom_range(0, 3), ref_job(cfg, len));
    end

`ifdef MAC_SEQ_OVF_CHECK_EN
    for (int t = 16; t <= 17; t++) begin
      job_w.delete(); job_a.delete();
      for (int k = 0; k < t; k++) begin
        job_w.push_back(8'd1);
        job_a.push_back(8'd1);
      end
      do_job(2'd0, t, 0, 0, ref_job(2'd0, t));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
